// File: rtl/frontend_seq_ctrl.sv
// Front-end sequencer: owns fetch enable, IF_ID stall/flush, ID flush
// and the PC redirect.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   i_stall_from_id     ID asks fetch to stall
//   i_al_full           allocation list full
//   i_loop_start        loop buffer takes over instruction supply
//   i_fnsh_unrll        loop buffer finished unrolling
//   i_jump_pending      indirect jump waiting on its base register
//   i_jump_base_rdy     RF jump base valid, i_jump_base is the target
//   i_has_mispredict    ROB mispredict, i_pc_recovery is the target
//   i_exter_pc_en       external PC load, i_exter_pc is the target
//   o_fetch_en          fetch may advance PC
//   o_if_id_stall       IF_ID holds its contents
//   o_if_id_flush       IF_ID loads a bubble
//   o_id_flush          ID discards its bundle
//   o_redirect_vld      one-cycle pulse, fetch loads o_pc_redirect
//   o_pc_redirect       last redirect target
//   o_jwait_timeout     sticky: jump base never arrived
//   o_stall_cnt         saturating STALL/JWAIT cycle count
//   o_state             BOOT=0 RUN=1 STALL=2 JWAIT=3 FLUSH=4 LOOP=5
module frontend_seq_ctrl #(
  parameter int PC_W         = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int JWAIT_MAX    = 15,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_stall_from_id,
  input  logic             i_al_full,
  input  logic             i_loop_start,
  input  logic             i_fnsh_unrll,
  input  logic             i_jump_pending,
  input  logic             i_jump_base_rdy,
  input  logic [PC_W-1:0]  i_jump_base,
  input  logic             i_has_mispredict,
  input  logic [PC_W-1:0]  i_pc_recovery,
  input  logic             i_exter_pc_en,
  input  logic [PC_W-1:0]  i_exter_pc,
  output logic             o_fetch_en,
  output logic             o_if_id_stall,
  output logic             o_if_id_flush,
  output logic             o_id_flush,
  output logic             o_redirect_vld,
  output logic [PC_W-1:0]  o_pc_redirect,
  output logic             o_jwait_timeout,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_RUN   = 3'd1,
    S_STALL = 3'd2,
    S_JWAIT = 3'd3,
    S_FLUSH = 3'd4,
    S_LOOP  = 3'd5
  } state_t;

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam int JW_W = $clog2(JWAIT_MAX + 1);
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [JW_W-1:0] JW_MAX  = JW_W'(JWAIT_MAX);

  state_t            r_state;
  logic [FC_W-1:0]   r_fcnt;
  logic [JW_W-1:0]   r_wcnt;
  logic              r_tmo;
  logic [PC_W-1:0]   r_pc;
  logic              r_rv;
  logic [CNT_W-1:0]  r_scnt;
  logic              r_fe;
  logic              r_stall;
  logic              r_flush;

  state_t            w_nxt_state;
  logic [FC_W-1:0]   w_nxt_fcnt;
  logic [JW_W-1:0]   w_nxt_wcnt;
  logic              w_nxt_tmo;
  logic [PC_W-1:0]   w_nxt_pc;
  logic [CNT_W-1:0]  w_nxt_scnt;
  logic              w_redir;
  logic [PC_W-1:0]   w_redir_pc;
  logic              w_bp;
  logic              w_jmp_rdy;

  assign w_bp      = i_stall_from_id | i_al_full;
  assign w_jmp_rdy = (r_state == S_JWAIT) & i_jump_base_rdy;
  assign w_redir   = (r_state != S_BOOT) &
                     (i_exter_pc_en | i_has_mispredict | w_jmp_rdy);

  // Source priority: external > mispredict > resolved jump.
  always_comb begin
    w_redir_pc = i_jump_base;
    if (i_exter_pc_en)
      w_redir_pc = i_exter_pc;
    else if (i_has_mispredict)
      w_redir_pc = i_pc_recovery;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_fcnt  = r_fcnt;
    w_nxt_wcnt  = r_wcnt;
    w_nxt_tmo   = r_tmo;
    w_nxt_pc    = r_pc;
    if (w_redir) begin
      w_nxt_state = S_FLUSH;
      w_nxt_fcnt  = FC_LOAD;
      w_nxt_pc    = w_redir_pc;
    end else begin
      unique case (r_state)
        S_BOOT: w_nxt_state = S_RUN;
        S_RUN: begin
          if (i_loop_start) begin
            w_nxt_state = S_LOOP;
          end else if (i_jump_pending) begin
            w_nxt_state = S_JWAIT;
            w_nxt_wcnt  = '0;
          end else if (w_bp) begin
            w_nxt_state = S_STALL;
          end
        end
        S_STALL: begin
          if (!w_bp) w_nxt_state = S_RUN;
        end
        S_JWAIT: begin
          // Counter parks at the limit; the flag is sticky.
          if (r_wcnt == JW_MAX) w_nxt_tmo = 1'b1;
          else w_nxt_wcnt = r_wcnt + JW_W'(1);
        end
        S_FLUSH: begin
          if (r_fcnt == '0)
            w_nxt_state = w_bp ? S_STALL : S_RUN;
          else
            w_nxt_fcnt = r_fcnt - FC_W'(1);
        end
        S_LOOP: begin
          if (i_fnsh_unrll) w_nxt_state = S_RUN;
        end
        default: w_nxt_state = S_BOOT;
      endcase
    end
  end

  always_comb begin
    w_nxt_scnt = r_scnt;
    if ((w_nxt_state == S_STALL || w_nxt_state == S_JWAIT) &&
        r_scnt != '1)
      w_nxt_scnt = r_scnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
      r_fcnt  <= '0;
      r_wcnt  <= '0;
      r_tmo   <= 1'b0;
      r_pc    <= '0;
      r_rv    <= 1'b0;
      r_scnt  <= '0;
      r_fe    <= 1'b0;
      r_stall <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_fcnt  <= w_nxt_fcnt;
      r_wcnt  <= w_nxt_wcnt;
      r_tmo   <= w_nxt_tmo;
      r_pc    <= w_nxt_pc;
      r_rv    <= w_redir;
      r_scnt  <= w_nxt_scnt;
      r_fe    <= (w_nxt_state == S_RUN) | (w_nxt_state == S_FLUSH);
      r_stall <= (w_nxt_state == S_STALL) | (w_nxt_state == S_JWAIT) |
                 (w_nxt_state == S_LOOP);
      r_flush <= (w_nxt_state == S_FLUSH);
    end
  end

  assign o_fetch_en      = r_fe;
  assign o_if_id_stall   = r_stall;
  assign o_if_id_flush   = r_flush;
  assign o_id_flush      = r_flush;
  assign o_redirect_vld  = r_rv;
  assign o_pc_redirect   = r_pc;
  assign o_jwait_timeout = r_tmo;
  assign o_stall_cnt     = r_scnt;
  assign o_state         = r_state;

endmodule
